ex_issue_ctrl: RTL and testbench

- Issue and sequencing controller for the execute stage.
- Decides each cycle whether the instruction held in decode may enter EX, using a 64-entry register scoreboard.
- Holds issue while a multi-cycle ALU operation runs.
- Generates fetch/decode flush bubbles after a taken branch from the EX latch.
- Sits between the decode control unit and the EX latch; drives the hold/flush inputs of the IF/ID latches.

---
 rtl/ex_issue_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: issue/sequencing controller for the execute stage.
// Decides whether the decoded instruction may enter EX. It uses a 64-entry
// pending-write scoreboard to detect hazards. It holds issue while a
// multi-cycle ALU op occupies EX and inserts flush bubbles after a taken branch.
// Optional feature macro: EX_ISSUE_FWD_EN. When it is defined, a one-entry
// tracker lets a dependent instruction issue straight after a single-cycle
// writer by selecting the EX-latch forward path.
module ex_issue_ctrl #(
    parameter int MUL_LAT   = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [5:0] id_rs1,
    input  logic [5:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [5:0] id_rd,
    input  logic       id_wr,
    input  logic       id_load,
    input  logic       id_multi,
    input  logic       ex_branch,
    input  logic       wb_valid,
    input  logic [5:0] wb_rd,
    output logic       issue,
    output logic       stall,
    output logic       flush,
    output logic       busy,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter load values: the issue cycle is the first EX cycle of a multi
    // op, and cnt==0 is the last cycle spent in the state.
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 2);
    localparam logic [3:0] FL_INIT  = 4'(FLUSH_CYC - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        flush_q;
    logic [63:0] pend;
    logic [63:0] pend_nxt;

    logic hz_a;
    logic hz_b;
    logic fwd_a_c;
    logic fwd_b_c;
    logic set_en;

`ifdef EX_ISSUE_FWD_EN
    logic       trk_vld;
    logic [5:0] trk_rd;
    logic       trk_set;
    logic       unused_fwd;

    // A dependent source matches the writer that issued last cycle
    assign fwd_a_c = id_use_rs1 & trk_vld & (trk_rd == id_rs1);
    assign fwd_b_c = id_use_rs2 & trk_vld & (trk_rd == id_rs2);
    assign hz_a    = id_use_rs1 & pend[id_rs1] & ~fwd_a_c;
    assign hz_b    = id_use_rs2 & pend[id_rs2] & ~fwd_b_c;

    // Single-cycle writers go through the forward path instead of the scoreboard
    assign trk_set = issue & id_wr & (id_rd != 6'd0) & ~id_load & ~id_multi;
    assign set_en  = issue & id_wr & (id_rd != 6'd0) & ~trk_set;
    assign unused_fwd = 1'b0;

    // Tracker holds the last forwardable writer for exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_vld <= 1'b0;
            trk_rd  <= 6'd0;
        end else begin
            trk_vld <= trk_set;
            trk_rd  <= id_rd;
        end
    end
`else
    logic unused_load;

    // Without forwarding, every writer goes through the scoreboard
    assign fwd_a_c     = 1'b0;
    assign fwd_b_c     = 1'b0;
    assign hz_a        = id_use_rs1 & pend[id_rs1];
    assign hz_b        = id_use_rs2 & pend[id_rs2];
    assign set_en      = issue & id_wr & (id_rd != 6'd0);
    assign unused_load = id_load;
`endif

    // Issue/stall decode; every control output is forced low while reset is held
    always_comb begin
        issue     = ~rst & id_valid & (state == RUN) & ~hz_a & ~hz_b & ~ex_branch;
        stall     = ~rst & id_valid & ~issue & ~flush_q;
        fwd_a     = ~rst & fwd_a_c;
        fwd_b     = ~rst & fwd_b_c;
        busy      = (state == MULTI);
        flush     = flush_q;
        state_out = state;
    end

    // Next scoreboard: the writeback clear is applied first so a same-cycle set
    // takes precedence. Register 0 is never pending.
    always_comb begin
        pend_nxt = pend;
        if (wb_valid) pend_nxt[wb_rd] = 1'b0;
        if (set_en)   pend_nxt[id_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= 64'd0;
        else     pend <= pend_nxt;
    end

    // Sequencing FSM. A taken branch overrides everything and restarts the bubble count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= 4'd0;
            flush_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_branch) begin
                        state   <= FLUSH;
                        cnt     <= FL_INIT;
                        flush_q <= 1'b1;
                    end else if (issue & id_multi) begin
                        state <= MULTI;
                        cnt   <= MUL_INIT;
                    end
                end
                MULTI: begin
                    if (ex_branch) begin
                        state   <= FLUSH;
                        cnt     <= FL_INIT;
                        flush_q <= 1'b1;
                    end else if (cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                FLUSH: begin
                    if (ex_branch) begin
                        cnt <= FL_INIT;
                    end else if (cnt == 4'd0) begin
                        state   <= RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= RUN;
                    cnt     <= 4'd0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: directed scenarios followed by random traffic.
// Both are compared every cycle against a remaining-cycles/pending-set model.
module tb_ex_issue_ctrl;

    localparam int MUL_LAT   = 4;
    localparam int FLUSH_CYC = 2;
`ifdef EX_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_rs1 = 6'd0;
    logic [5:0] id_rs2 = 6'd0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [5:0] id_rd = 6'd0;
    logic       id_wr = 1'b0;
    logic       id_load = 1'b0;
    logic       id_multi = 1'b0;
    logic       ex_branch = 1'b0;
    logic       wb_valid = 1'b0;
    logic [5:0] wb_rd = 6'd0;
    logic       issue, stall, flush, busy, fwd_a, fwd_b;
    logic [1:0] state_out;

    ex_issue_ctrl #(.MUL_LAT(MUL_LAT), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
        .id_load(id_load), .id_multi(id_multi), .ex_branch(ex_branch),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .issue(issue), .stall(stall), .flush(flush),
        .busy(busy), .fwd_a(fwd_a), .fwd_b(fwd_b), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: set of pending registers plus remaining cycles in each mode
    bit [63:0] m_pend;
    int        m_mul;
    int        m_fl;
    bit        m_tv;
    bit [5:0]  m_tr;
    bit        e_issue, e_stall, e_flush, e_busy, e_fa, e_fb;
    bit [1:0]  e_state;

    task automatic model_reset();
        m_pend = '0; m_mul = 0; m_fl = 0; m_tv = 0; m_tr = '0;
    endtask

    task automatic model_comb();
        bit hz;
        if (rst) model_reset();
        e_flush = (m_fl > 0);
        e_busy  = !e_flush && (m_mul > 0);
        e_state = e_flush ? 2'd2 : (e_busy ? 2'd1 : 2'd0);
        e_fa    = FWD && !rst && id_use_rs1 && m_tv && (m_tr == id_rs1);
        e_fb    = FWD && !rst && id_use_rs2 && m_tv && (m_tr == id_rs2);
        hz      = (id_use_rs1 && m_pend[id_rs1] && !e_fa) || (id_use_rs2 && m_pend[id_rs2] && !e_fb);
        e_issue = !rst && id_valid && !e_flush && !e_busy && !hz && !ex_branch;
        e_stall = !rst && id_valid && !e_issue && !e_flush;
    endtask

    task automatic model_edge();
        bit writer, fw;
        if (rst) begin
            model_reset();
            return;
        end
        model_comb();
        if (wb_valid) m_pend[wb_rd] = 1'b0;
        writer = e_issue && id_wr && (id_rd != 6'd0);
        fw     = FWD && writer && !id_load && !id_multi;
        if (writer && !fw) m_pend[id_rd] = 1'b1;
        m_tv = fw;
        m_tr = id_rd;
        if (ex_branch) begin
            m_fl  = FLUSH_CYC;
            m_mul = 0;
        end else if (m_fl > 0)  m_fl--;
        else if (m_mul > 0)     m_mul--;
        else if (e_issue && id_multi) m_mul = MUL_LAT - 1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic cycle();
        @(negedge clk);
        model_comb();
        vectors++;
        chk("issue", {1'b0, issue}, {1'b0, e_issue});
        chk("stall", {1'b0, stall}, {1'b0, e_stall});
        chk("flush", {1'b0, flush}, {1'b0, e_flush});
        chk("busy", {1'b0, busy}, {1'b0, e_busy});
        chk("fwd_a", {1'b0, fwd_a}, {1'b0, e_fa});
        chk("fwd_b", {1'b0, fwd_b}, {1'b0, e_fb});
        chk("state_out", state_out, e_state);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_wr = 0; id_load = 0; id_multi = 0; ex_branch = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic instr(input bit v, input bit [5:0] r1, input bit u1, input bit [5:0] r2,
                         input bit u2, input bit [5:0] rd, input bit wr, input bit ld, input bit mul);
        id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = rd; id_wr = wr; id_load = ld; id_multi = mul;
    endtask

    task automatic clean();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        cycle();

        // RAW hazard on r5, released by writeback
        instr(1, 0, 0, 0, 0, 5, 1, 0, 0);
        cycle();
        instr(1, 5, 1, 0, 0, 6, 1, 0, 0);
        #1;
`ifdef EX_ISSUE_FWD_EN
        chk("raw_fwd_a", {1'b0, fwd_a}, 2'd1);
        chk("raw_fwd_issue", {1'b0, issue}, 2'd1);
`else
        chk("raw_stall", {1'b0, stall}, 2'd1);
        chk("raw_issue", {1'b0, issue}, 2'd0);
`endif
        cycle();
        cycle();
        wb_valid = 1; wb_rd = 5;
        cycle();
        wb_valid = 0;
        #1 chk("raw_release", {1'b0, issue}, 2'd1);
        cycle();

        // Multi-cycle op blocks an independent instruction for MUL_LAT-1 cycles
        clean();
        instr(1, 0, 0, 0, 0, 10, 1, 0, 1);
        cycle();
        instr(1, 1, 1, 0, 0, 11, 1, 0, 0);
        #1 chk("multi_busy", {1'b0, busy}, 2'd1);
        chk("multi_stall", {1'b0, stall}, 2'd1);
        cycle();
        cycle();
        cycle();
        #1 chk("multi_done_issue", {1'b0, issue}, 2'd1);
        chk("multi_done_busy", {1'b0, busy}, 2'd0);
        cycle();

        // Async reset in the first MULTI cycle
        clean();
        instr(1, 0, 0, 0, 0, 12, 1, 0, 1);
        cycle();
        idle();
        rst = 1;
        #1 chk("rst_state", state_out, 2'd0);
        chk("rst_busy", {1'b0, busy}, 2'd0);
        cycle();
        rst = 0;
        instr(1, 5, 1, 0, 0, 13, 1, 0, 0);
        #1 chk("rst_issue", {1'b0, issue}, 2'd1);
        chk("rst_stall", {1'b0, stall}, 2'd0);
        cycle();

        // Taken branch in RUN: no issue, FLUSH_CYC bubbles, r7 never marked
        clean();
        instr(1, 0, 0, 0, 0, 7, 1, 0, 0);
        ex_branch = 1;
        #1 chk("br_issue", {1'b0, issue}, 2'd0);
        cycle();
        ex_branch = 0;
        instr(1, 7, 1, 0, 0, 8, 0, 0, 0);
        #1 chk("br_flush1", {1'b0, flush}, 2'd1);
        chk("br_stall", {1'b0, stall}, 2'd0);
        cycle();
        #1 chk("br_flush2", {1'b0, flush}, 2'd1);
        cycle();
        #1 chk("br_flush_end", {1'b0, flush}, 2'd0);
        chk("br_state", state_out, 2'd0);
        chk("br_r7_clear", {1'b0, issue}, 2'd1);
        cycle();

        // Same-cycle set and clear of r9, then r0 writer never blocks r0 reader
        clean();
        instr(1, 0, 0, 0, 0, 9, 1, 0, 0);
        cycle();
        wb_valid = 1; wb_rd = 9;
        cycle();
        wb_valid = 0;
        instr(1, 9, 1, 0, 0, 0, 0, 0, 0);
`ifndef EX_ISSUE_FWD_EN
        #1 chk("simul_set_wins", {1'b0, stall}, 2'd1);
`endif
        cycle();
        instr(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        instr(1, 0, 1, 0, 1, 3, 0, 0, 0);
        #1 chk("r0_no_stall", {1'b0, stall}, 2'd0);
        cycle();

        // Branch at MULTI cnt=1
        clean();
        instr(1, 0, 0, 0, 0, 14, 1, 0, 1);
        cycle();
        idle();
        cycle();
        ex_branch = 1;
        #1 chk("bm_busy_before", {1'b0, busy}, 2'd1);
        cycle();
        ex_branch = 0;
        #1 chk("bm_busy", {1'b0, busy}, 2'd0);
        chk("bm_state", state_out, 2'd2);
        cycle();
        #1 chk("bm_flush2", {1'b0, flush}, 2'd1);
        cycle();
        #1 chk("bm_flush_end", {1'b0, flush}, 2'd0);
        cycle();

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            id_valid   = ($urandom_range(3) != 0);
            id_rs1     = 6'($urandom_range(7));
            id_rs2     = 6'($urandom_range(7));
            id_use_rs1 = 1'($urandom_range(1));
            id_use_rs2 = 1'($urandom_range(1));
            id_rd      = 6'($urandom_range(7));
            id_wr      = 1'($urandom_range(1));
            id_load    = ($urandom_range(7) == 0);
            id_multi   = ($urandom_range(15) == 0);
            ex_branch  = ($urandom_range(15) == 0);
            wb_valid   = 1'($urandom_range(1));
            wb_rd      = 6'($urandom_range(7));
            rst        = ($urandom_range(199) == 0);
            cycle();
        end
        rst = 0;
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
